// File: rtl/kbd_pkg.sv
// Shared PS/2 keyboard definitions: set-2 scan-code constants, the decoder
// state type and the queued key-event entry.
package kbd_pkg;

  localparam logic [7:0] ScE0     = 8'hE0;
  localparam logic [7:0] ScF0     = 8'hF0;
  localparam logic [7:0] ScLShift = 8'h12;
  localparam logic [7:0] ScRShift = 8'h59;
  localparam logic [7:0] ScCaps   = 8'h58;

  typedef enum logic [1:0] {
    StIdle,
    StExt,
    StBreak,
    StExtBrk
  } kbd_state_e;

  typedef struct packed {
    logic       rel;
    logic       ext;
    logic [7:0] code;
  } kbd_entry_t;

  function automatic logic is_modifier(input logic [7:0] code);
    return (code == ScLShift) || (code == ScRShift) || (code == ScCaps);
  endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word fall-through event FIFO with occupancy count and a sticky
// overflow flag; a push into a full FIFO is accepted only alongside a pop.
module key_fifo #(
  parameter int unsigned DEPTH   = 8,
  parameter type         entry_t = logic [9:0]
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  entry_t                       i_data,
  input  logic                         i_pop,
  input  logic                         i_clr_ovf,
  output entry_t                       o_data,
  output logic                         o_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  entry_t            r_mem [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic              r_overflow;
  logic              w_full;
  logic              w_pop;
  logic              w_push;

  assign w_full = (r_count == CntW'(DEPTH));
  assign w_pop  = i_pop & (r_count != '0);
  assign w_push = i_push & (~w_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CntW'(1);
      // A dropped event outranks a clear in the same cycle
      if (i_push && !w_push) r_overflow <= 1'b1;
      else if (i_clr_ovf)    r_overflow <= 1'b0;
    end
  end

  assign o_data     = r_mem[r_rd_ptr];
  assign o_valid    = (r_count != '0);
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_interface2.sv
// PS/2 device-to-host receiver: synchronises the pins, shifts in an 11-bit
// frame on falling PS/2 clock edges and pulses o_byte_strobe for a good frame.
module ps2_interface2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_strobe,
  output logic [7:0] o_code
);

  logic [2:0] r_clk_sync;
  logic [1:0] r_data_sync;
  logic [9:0] r_shift;
  logic [3:0] r_bit_cnt;
  logic       r_strobe;
  logic [7:0] r_code;
  logic       w_fall;
  logic       w_frame_ok;

  assign w_fall = r_clk_sync[2] & ~r_clk_sync[1];
  // r_shift holds start, data[7:0], parity; the bit now on the pin is the stop bit
  assign w_frame_ok = ~r_shift[0] & r_data_sync[1] & (^r_shift[9:1]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_sync  <= 3'b111;
      r_data_sync <= 2'b11;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_strobe    <= 1'b0;
      r_code      <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[1:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
      r_strobe    <= 1'b0;
      if (w_fall) begin
        if (r_bit_cnt == 4'd10) begin
          r_bit_cnt <= '0;
          if (w_frame_ok) begin
            r_code   <= r_shift[8:1];
            r_strobe <= 1'b1;
          end
        end else begin
          r_shift   <= {r_data_sync[1], r_shift[9:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end
    end
  end

  assign o_byte_strobe = r_strobe;
  assign o_code        = r_code;

endmodule

// File: rtl/scancode_to_ascii.sv
// Set-2 scan code to ASCII (unshifted) lookup; unmapped codes give 0.
module scancode_to_ascii (
  input  logic [7:0] i_code,
  output logic [7:0] o_ascii
);

  always_comb begin
    o_ascii = 8'h00;
    case (i_code)
      8'h1C: o_ascii = 8'h61;  8'h32: o_ascii = 8'h62;  8'h21: o_ascii = 8'h63;
      8'h23: o_ascii = 8'h64;  8'h24: o_ascii = 8'h65;  8'h2B: o_ascii = 8'h66;
      8'h34: o_ascii = 8'h67;  8'h33: o_ascii = 8'h68;  8'h43: o_ascii = 8'h69;
      8'h3B: o_ascii = 8'h6A;  8'h42: o_ascii = 8'h6B;  8'h4B: o_ascii = 8'h6C;
      8'h3A: o_ascii = 8'h6D;  8'h31: o_ascii = 8'h6E;  8'h44: o_ascii = 8'h6F;
      8'h4D: o_ascii = 8'h70;  8'h15: o_ascii = 8'h71;  8'h2D: o_ascii = 8'h72;
      8'h1B: o_ascii = 8'h73;  8'h2C: o_ascii = 8'h74;  8'h3C: o_ascii = 8'h75;
      8'h2A: o_ascii = 8'h76;  8'h1D: o_ascii = 8'h77;  8'h22: o_ascii = 8'h78;
      8'h35: o_ascii = 8'h79;  8'h1A: o_ascii = 8'h7A;
      8'h45: o_ascii = 8'h30;  8'h16: o_ascii = 8'h31;  8'h1E: o_ascii = 8'h32;
      8'h26: o_ascii = 8'h33;  8'h25: o_ascii = 8'h34;  8'h2E: o_ascii = 8'h35;
      8'h36: o_ascii = 8'h36;  8'h3D: o_ascii = 8'h37;  8'h3E: o_ascii = 8'h38;
      8'h46: o_ascii = 8'h39;
      8'h29: o_ascii = 8'h20;  8'h5A: o_ascii = 8'h0D;  8'h66: o_ascii = 8'h08;
      8'h0D: o_ascii = 8'h09;  8'h76: o_ascii = 8'h1B;
      default: o_ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/keyboard_fifo.sv
// PS/2 keyboard front end: decodes make/break/E0 sequences, tracks Shift and
// Caps Lock, and queues key events (ASCII or raw) for the CPU to read.
module keyboard_fifo
  import kbd_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter bit          RAW_MODE = 1'b0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       keyboard_clock,
  input  logic                       keyboard_data,
  input  logic                       key_read,
  input  logic                       clear_overflow,
  output logic                       key_valid,
  output logic [7:0]                 key_data,
  output logic                       key_ext,
  output logic                       key_release,
  output logic [$clog2(DEPTH+1)-1:0] key_count,
  output logic                       shift_active,
  output logic                       caps_active,
  output logic                       overflow
);

  logic       w_strobe;
  logic [7:0] w_code;
  logic [7:0] w_ascii;
  logic       w_byte_vld;
  kbd_state_e r_state;
  kbd_state_e w_next_state;
  logic       w_make;
  logic       w_brk;
  logic       w_ext;
  logic       r_lshift;
  logic       r_rshift;
  logic       r_caps;
  logic       w_push;
  kbd_entry_t w_entry;
  kbd_entry_t w_head;

  ps2_interface2 u_ps2 (
    .i_clk         (CLK),
    .i_rst         (RST),
    .i_ps2_clk     (keyboard_clock),
    .i_ps2_data    (keyboard_data),
    .o_byte_strobe (w_strobe),
    .o_code        (w_code)
  );

  scancode_to_ascii u_ascii (
    .i_code  (w_code),
    .o_ascii (w_ascii)
  );

  assign w_byte_vld = w_strobe & ~RST;

  always_ff @(posedge CLK) begin
    if (RST)             r_state <= StIdle;
    else if (w_byte_vld) r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = StIdle;
    unique case (r_state)
      StIdle: begin
        if (w_code == ScE0)      w_next_state = StExt;
        else if (w_code == ScF0) w_next_state = StBreak;
      end
      StExt:    if (w_code == ScF0) w_next_state = StExtBrk;
      StBreak:  w_next_state = StIdle;
      StExtBrk: w_next_state = StIdle;
      default:  w_next_state = StIdle;
    endcase
  end

  always_comb begin
    w_make = 1'b0;
    w_brk  = 1'b0;
    w_ext  = 1'b0;
    if (w_byte_vld) begin
      unique case (r_state)
        StIdle:   w_make = (w_code != ScE0) && (w_code != ScF0);
        StExt: begin
          w_make = (w_code != ScF0);
          w_ext  = 1'b1;
        end
        StBreak:  w_brk = 1'b1;
        StExtBrk: begin
          w_brk = 1'b1;
          w_ext = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_caps   <= 1'b0;
    end else if (!w_ext) begin
      if (w_code == ScLShift && (w_make || w_brk)) r_lshift <= w_make;
      if (w_code == ScRShift && (w_make || w_brk)) r_rshift <= w_make;
      if (w_code == ScCaps && w_make)              r_caps   <= ~r_caps;
    end
  end

  // Case folding uses the modifier state from before the current event
  always_comb begin
    w_entry = '0;
    w_push  = 1'b0;
    if (RAW_MODE) begin
      w_push       = w_make | w_brk;
      w_entry.rel  = w_brk;
      w_entry.ext  = w_ext;
      w_entry.code = w_code;
    end else begin
      w_push       = w_make & ~w_ext & (w_ascii != 8'h00) & ~is_modifier(w_code);
      w_entry.code = w_ascii;
      if (w_ascii >= 8'h61 && w_ascii <= 8'h7A && ((r_lshift | r_rshift) ^ r_caps)) begin
        w_entry.code = w_ascii - 8'h20;
      end
    end
  end

  key_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (kbd_entry_t)
  ) u_fifo (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_push     (w_push),
    .i_data     (w_entry),
    .i_pop      (key_read),
    .i_clr_ovf  (clear_overflow),
    .o_data     (w_head),
    .o_valid    (key_valid),
    .o_count    (key_count),
    .o_overflow (overflow)
  );

  assign key_data     = key_valid ? w_head.code : 8'h00;
  assign key_ext      = key_valid & w_head.ext;
  assign key_release  = key_valid & w_head.rel;
  assign shift_active = r_lshift | r_rshift;
  assign caps_active  = r_caps;

endmodule

// File: tb/tb_keyboard_fifo.sv
// Directed bench: three keyboard_fifo configurations share the PS/2 pins and
// controls; each scenario resets all of them and checks the relevant one.
module tb_keyboard_fifo;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic kb_clk = 1'b1;
  logic kb_data = 1'b1;
  logic key_read = 1'b0;
  logic clr_ovf = 1'b0;

  logic       a_valid, a_ext, a_rel, a_shift, a_caps, a_ovf;
  logic [7:0] a_data;
  logic [3:0] a_count;
  logic       r_valid, r_ext, r_rel, r_shift, r_caps, r_ovf;
  logic [7:0] r_data;
  logic [3:0] r_count;
  logic       s_valid, s_ext, s_rel, s_shift, s_caps, s_ovf;
  logic [7:0] s_data;
  logic [2:0] s_count;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 CLK = ~CLK;

  keyboard_fifo #(.DEPTH(8), .RAW_MODE(1'b0)) dut (
    .CLK (CLK), .RST (RST), .keyboard_clock (kb_clk), .keyboard_data (kb_data),
    .key_read (key_read), .clear_overflow (clr_ovf), .key_valid (a_valid),
    .key_data (a_data), .key_ext (a_ext), .key_release (a_rel), .key_count (a_count),
    .shift_active (a_shift), .caps_active (a_caps), .overflow (a_ovf)
  );

  keyboard_fifo #(.DEPTH(8), .RAW_MODE(1'b1)) dut_raw (
    .CLK (CLK), .RST (RST), .keyboard_clock (kb_clk), .keyboard_data (kb_data),
    .key_read (key_read), .clear_overflow (clr_ovf), .key_valid (r_valid),
    .key_data (r_data), .key_ext (r_ext), .key_release (r_rel), .key_count (r_count),
    .shift_active (r_shift), .caps_active (r_caps), .overflow (r_ovf)
  );

  keyboard_fifo #(.DEPTH(4), .RAW_MODE(1'b0)) dut4 (
    .CLK (CLK), .RST (RST), .keyboard_clock (kb_clk), .keyboard_data (kb_data),
    .key_read (key_read), .clear_overflow (clr_ovf), .key_valid (s_valid),
    .key_data (s_data), .key_ext (s_ext), .key_release (s_rel), .key_count (s_count),
    .shift_active (s_shift), .caps_active (s_caps), .overflow (s_ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic pop();
    @(negedge CLK);
    key_read = 1'b1;
    @(negedge CLK);
    key_read = 1'b0;
  endtask

  // mode 0: plain; 1: check key_valid timing after stop-bit fall (DUT empty);
  // 2: raise key_read so the pop lands on the same edge as the push
  task automatic send_byte(input logic [7:0] b, input int mode);
    logic [10:0] frame;
    frame = {1'b1, ~^b, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      kb_data = frame[i];
      repeat (4) @(negedge CLK);
      kb_clk = 1'b0;
      if (i == 10 && mode == 1) begin
        repeat (3) @(posedge CLK);
        #1 check_eq("latency_before", 32'(a_valid), 32'd0);
        @(posedge CLK);
        #1 check_eq("latency_after", 32'(a_valid), 32'd1);
      end else if (i == 10 && mode == 2) begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        key_read = 1'b1;
        @(posedge CLK);
        #1 key_read = 1'b0;
      end
      repeat (4) @(negedge CLK);
      kb_clk = 1'b1;
    end
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    do_reset();
    check_eq("rst_valid", 32'(a_valid), 32'd0);
    check_eq("rst_data", 32'(a_data), 32'd0);
    check_eq("rst_count", 32'(a_count), 32'd0);
    check_eq("rst_flags", 32'({a_ext, a_rel, a_shift, a_caps, a_ovf}), 32'd0);

    // 'a' make then break: one lowercase entry
    send_byte(8'h1C, 1);
    send_byte(8'hF0, 0);
    send_byte(8'h1C, 0);
    check_eq("a_count", 32'(a_count), 32'd1);
    check_eq("a_data", 32'(a_data), 32'h61);

    // Shift held while typing 'a'
    do_reset();
    send_byte(8'h12, 0);
    check_eq("shift_on", 32'(a_shift), 32'd1);
    send_byte(8'h1C, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h1C, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h12, 0);
    check_eq("shift_off", 32'(a_shift), 32'd0);
    check_eq("shift_count", 32'(a_count), 32'd1);
    check_eq("shift_data", 32'(a_data), 32'h41);

    // Caps Lock toggle, then Shift cancels it
    do_reset();
    send_byte(8'h58, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h58, 0);
    send_byte(8'h1C, 0);
    check_eq("caps_on", 32'(a_caps), 32'd1);
    check_eq("caps_data", 32'(a_data), 32'h41);
    send_byte(8'h12, 0);
    send_byte(8'h1C, 0);
    check_eq("caps_shift_count", 32'(a_count), 32'd2);
    pop();
    check_eq("caps_shift_data", 32'(a_data), 32'h61);

    // Raw mode: extended make and break
    do_reset();
    send_byte(8'hE0, 0);
    send_byte(8'h75, 0);
    send_byte(8'hE0, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h75, 0);
    check_eq("raw_count", 32'(r_count), 32'd2);
    check_eq("raw_head0", 32'({r_ext, r_rel, r_data}), 32'h275);
    pop();
    check_eq("raw_head1", 32'({r_ext, r_rel, r_data}), 32'h375);

    // DEPTH=4 overflow: a b c d e with no reads
    do_reset();
    send_byte(8'h1C, 0);
    send_byte(8'h32, 0);
    send_byte(8'h21, 0);
    send_byte(8'h23, 0);
    send_byte(8'h24, 0);
    check_eq("full_count", 32'(s_count), 32'd4);
    check_eq("full_ovf", 32'(s_ovf), 32'd1);
    check_eq("full_head", 32'(s_data), 32'h61);
    @(negedge CLK);
    clr_ovf = 1'b1;
    @(negedge CLK);
    clr_ovf = 1'b0;
    check_eq("ovf_cleared", 32'(s_ovf), 32'd0);

    // Full with push and pop on the same edge: 'f' accepted, 'a' removed
    send_byte(8'h2B, 2);
    check_eq("pushpop_count", 32'(s_count), 32'd4);
    check_eq("pushpop_ovf", 32'(s_ovf), 32'd0);
    check_eq("pushpop_head", 32'(s_data), 32'h62);
    pop();
    pop();
    pop();
    check_eq("tail_count", 32'(s_count), 32'd1);
    check_eq("tail_data", 32'(s_data), 32'h66);

    // Reset after E0 forgets the prefix; also push+pop while empty
    do_reset();
    send_byte(8'hE0, 0);
    do_reset();
    send_byte(8'h1C, 2);
    check_eq("rstpfx_count", 32'(a_count), 32'd1);
    check_eq("rstpfx_data", 32'(a_data), 32'h61);
    check_eq("rstpfx_raw", 32'({r_ext, r_rel, r_data}), 32'h01C);
    check_eq("rstpfx_raw_count", 32'(r_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
